battle_director: RTL and testbench
==================================

Name: battle_director

Overview:
- Game-flow controller on the initiating side of the battle handshake.
- Runs the title screen and a 3-pick team-selection menu driven by keycode.
- Once the team is chosen, drives `team` and raises `is_battle`, then waits for the battle engine's one-cycle `end_battle`.
- Captures `result` into a win/loss scoreboard and shows a timed result screen before returning to title.

Parameters:
- NUM_SPECIES, 6: number of selectable species ids, 0..NUM_SPECIES-1 (max 8).
- RESULT_HOLD, 16'd600: cycles the Result screen is held before auto-return to Title.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- keycode  in  8  current USB keycode (level, 0 = no key).
- end_battle  in  1  one-cycle pulse from battle engine: battle finished.
- result  in  1  valid with end_battle: 1 = player won, 0 = player lost.
- is_battle  out  1  battle request/hold to battle engine.
- team  out  [2:0][2:0]  chosen species ids, slot 0..2.
- cursor  out  3  species id under the selection cursor.
- picked_count  out  2  number of slots filled, 0..3.
- screen  out  2  0 Title, 1 Select, 2 Battle (Arm/InBattle), 3 Result.
- last_result  out  1  result of most recent battle.
- wins  out  8  battles won, saturating.
- losses  out  8  battles lost, saturating.

Behaviour:
- Reset values:
  - State Title; all outputs 0 (team slots all 0; cursor, picked_count, screen, wins, losses, last_result 0; is_battle 0).
  - prev_key 0; hold counter 0.
- Key event:
  - prev_key <= keycode every cycle.
  - key_evt = (keycode != 0) && (keycode != prev_key).
  - Held keys produce exactly one event. Changing directly from one nonzero key to another produces an event.
  - Codes: W 8'h1A, A 8'h04, S 8'h16, D 8'h07, ENTER 8'h28.
- All outputs are registered or decoded from registered state (Moore); no combinational path from keycode/end_battle to any output.
- Title (screen 0):
  - ENTER event -> Select.
  - On that transition, picked_count <= 0, team <= 0, cursor <= 0.
- Select (screen 1):
  - D event: cursor <= cursor+1, wrapping NUM_SPECIES-1 -> 0.
  - A event: cursor <= cursor-1, wrapping 0 -> NUM_SPECIES-1.
  - ENTER event:
    - If cursor equals team[i] for any i < picked_count, ignore (no duplicates).
    - Otherwise team[picked_count] <= cursor and picked_count++.
    - If this fills slot 2 (picked_count becomes 3) -> Arm.
  - S event: if picked_count > 0, picked_count-- and the vacated slot <= 0; else ignore.
  - W and other keys are ignored.
- Arm (screen 2): one cycle, is_battle = 0, team stable; unconditionally -> InBattle.
- InBattle (screen 2):
  - is_battle = 1 continuously; team held constant; keycode ignored by this block.
  - On end_battle = 1:
    - last_result <= result.
    - If result, wins++ (saturates at 255); else losses++ (saturates at 255).
    - Hold counter <= RESULT_HOLD; -> Result.
  - is_battle therefore drops the cycle after end_battle is sampled, so the engine, now back in its Wait state, is not restarted.
- Result (screen 3):
  - is_battle = 0; counter decrements by 1 per cycle.
  - -> Title when an ENTER event occurs or the counter == 0 (whichever comes first).
  - If RESULT_HOLD = 0, leave Result after one cycle.
- end_battle in any state other than InBattle: ignored, scoreboard unchanged.
- Reset asserted in any state, including mid-battle: next cycle is Title with reset values; is_battle = 0; the scoreboard clears as well.
- picked_count never exceeds 3; cursor never reaches NUM_SPECIES.

Test Plan:
- Reset, then ENTER press/release -> screen 1, cursor 0, picked_count 0. Holding ENTER 50 cycles yields only one transition.
- In Select: A from cursor 0 -> cursor 5. D, D -> cursor 1. ENTER -> team[0] = 1, picked_count 1. ENTER again on 1 -> ignored, picked_count stays 1.
- Pick 1, 3, then S -> picked_count 1, team[1] = 0. Then pick 4, 2 -> team = {2,4,1} (slot2..0), Arm for exactly 1 cycle with is_battle 0, then is_battle 1.
- In InBattle, pulse end_battle with result 1 -> next cycle is_battle 0, screen 3, wins 1, last_result 1. With RESULT_HOLD = 5 and no keys, screen returns to 0 after 5-6 cycles.
- Force wins to 255 via repeated battles (or preload in sim), then another win -> wins stays 255. A loss increments losses only.
- Reset pulsed mid-InBattle -> next cycle screen 0, is_battle 0, team 0, wins/losses 0. An end_battle pulse while in Title -> no change.

Source files
------------

// File: rtl/battle_director_if.sv
// Battle handshake between the game-flow director (master) and the battle engine (slave).
interface battle_director_if;
    logic             is_battle;   // director -> engine: start/hold the battle
    logic [2:0][2:0]  team;        // director -> engine: chosen species, slot 0..2
    logic             end_battle;  // engine -> director: one-cycle finish pulse
    logic             result;      // engine -> director: 1 = player won

    modport master (output is_battle, team, input end_battle, result);
    modport slave  (input is_battle, team, output end_battle, result);
endinterface

// File: rtl/battle_director.sv
// Game-flow controller: title screen, 3-pick team selection, battle request,
// win/loss scoreboard and a timed result screen. All outputs are Moore.
module battle_director #(
    parameter int          NUM_SPECIES = 6,
    parameter logic [15:0] RESULT_HOLD = 16'd600
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [7:0]         keycode,
    battle_director_if.master  bus,
    output logic [2:0]         cursor,
    output logic [1:0]         picked_count,
    output logic [1:0]         screen,
    output logic               last_result,
    output logic [7:0]         wins,
    output logic [7:0]         losses
);
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [2:0] MAX_ID    = 3'(NUM_SPECIES - 1);

    typedef enum logic [2:0] {S_TITLE, S_SELECT, S_ARM, S_BATTLE, S_RESULT} state_t;

    state_t          state_q, state_d;
    logic [7:0]      prev_key_q, prev_key_d;
    logic [2:0]      cursor_q, cursor_d;
    logic [1:0]      picked_q, picked_d;
    logic [2:0][2:0] team_q, team_d;
    logic            last_q, last_d;
    logic [7:0]      wins_q, wins_d;
    logic [7:0]      losses_q, losses_d;
    logic [15:0]     hold_q, hold_d;

    logic key_evt, dup;

    // A key event fires once per press: on a new nonzero code, including key-to-key changes.
    always_comb begin
        key_evt = (keycode != 8'h00) && (keycode != prev_key_q);
    end

    // Cursor already present among the filled slots -> ENTER must not pick it again.
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if ((2'(i) < picked_q) && (team_q[i] == cursor_q)) dup = 1'b1;
        end
    end

    // Next-state and datapath updates for the whole game flow.
    always_comb begin
        state_d    = state_q;
        prev_key_d = keycode;
        cursor_d   = cursor_q;
        picked_d   = picked_q;
        team_d     = team_q;
        last_d     = last_q;
        wins_d     = wins_q;
        losses_d   = losses_q;
        hold_d     = hold_q;

        case (state_q)
            S_TITLE: begin
                if (key_evt && keycode == KEY_ENTER) begin
                    state_d  = S_SELECT;
                    picked_d = 2'd0;
                    team_d   = '0;
                    cursor_d = 3'd0;
                end
            end
            S_SELECT: begin
                if (key_evt) begin
                    case (keycode)
                        KEY_D: cursor_d = (cursor_q == MAX_ID) ? 3'd0 : cursor_q + 3'd1;
                        KEY_A: cursor_d = (cursor_q == 3'd0) ? MAX_ID : cursor_q - 3'd1;
                        KEY_ENTER: begin
                            if (!dup) begin
                                for (int i = 0; i < 3; i++) begin
                                    if (2'(i) == picked_q) team_d[i] = cursor_q;
                                end
                                picked_d = picked_q + 2'd1;
                                if (picked_q == 2'd2) state_d = S_ARM;
                            end
                        end
                        KEY_S: begin
                            if (picked_q != 2'd0) begin
                                for (int i = 0; i < 3; i++) begin
                                    if (2'(i) == picked_q - 2'd1) team_d[i] = 3'd0;
                                end
                                picked_d = picked_q - 2'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            // One quiet cycle so the engine sees a stable team before is_battle rises.
            S_ARM: state_d = S_BATTLE;
            S_BATTLE: begin
                if (bus.end_battle) begin
                    last_d = bus.result;
                    if (bus.result) begin
                        if (wins_q != 8'hFF) wins_d = wins_q + 8'd1;
                    end else begin
                        if (losses_q != 8'hFF) losses_d = losses_q + 8'd1;
                    end
                    hold_d  = RESULT_HOLD;
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                if ((key_evt && keycode == KEY_ENTER) || hold_q == 16'd0) begin
                    state_d = S_TITLE;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            default: state_d = S_TITLE;
        endcase
    end

    // State and scoreboard registers; reset clears everything including the score.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_TITLE;
            prev_key_q <= 8'h00;
            cursor_q   <= 3'd0;
            picked_q   <= 2'd0;
            team_q     <= '0;
            last_q     <= 1'b0;
            wins_q     <= 8'd0;
            losses_q   <= 8'd0;
            hold_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            prev_key_q <= prev_key_d;
            cursor_q   <= cursor_d;
            picked_q   <= picked_d;
            team_q     <= team_d;
            last_q     <= last_d;
            wins_q     <= wins_d;
            losses_q   <= losses_d;
            hold_q     <= hold_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        case (state_q)
            S_TITLE:         screen = 2'd0;
            S_SELECT:        screen = 2'd1;
            S_ARM, S_BATTLE: screen = 2'd2;
            default:         screen = 2'd3;
        endcase
        bus.is_battle = (state_q == S_BATTLE);
        bus.team      = team_q;
        cursor        = cursor_q;
        picked_count  = picked_q;
        last_result   = last_q;
        wins          = wins_q;
        losses        = losses_q;
    end
endmodule

// File: tb/tb_battle_director.sv
// Bench for battle_director: directed vector table, hand-written multi-cycle
// sequences, and random keys/pulses, all against a queue-based game model.
module tb_battle_director;
    localparam int NSP  = 6;
    localparam int HOLD = 5;
    localparam logic [7:0] K_W = 8'h1A, K_A = 8'h04, K_S = 8'h16, K_D = 8'h07, K_EN = 8'h28;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic [2:0] cursor;
    logic [1:0] picked_count, screen;
    logic       last_result;
    logic [7:0] wins, losses;

    battle_director_if bif();

    battle_director #(.NUM_SPECIES(NSP), .RESULT_HOLD(16'(HOLD))) dut (
        .Clk(Clk), .Reset(Reset), .keycode(keycode), .bus(bif.master),
        .cursor(cursor), .picked_count(picked_count), .screen(screen),
        .last_result(last_result), .wins(wins), .losses(losses)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // mode: 0 title, 1 select, 2 arm, 3 battle, 4 result
    int m_mode, m_cursor, m_wins, m_losses, m_last, m_hold, m_prev;
    int picks[$];

    function automatic void model_step(input bit rst, input int key, input bit eb, input bit res);
        bit evt;
        bit seen;
        if (rst) begin
            m_mode = 0; m_cursor = 0; picks.delete();
            m_wins = 0; m_losses = 0; m_last = 0; m_hold = 0; m_prev = 0;
            return;
        end
        evt = (key != 0) && (key != m_prev);
        m_prev = key;
        case (m_mode)
            0: if (evt && key == K_EN) begin m_mode = 1; picks.delete(); m_cursor = 0; end
            1: if (evt) begin
                if (key == K_D) m_cursor = (m_cursor + 1) % NSP;
                else if (key == K_A) m_cursor = (m_cursor + NSP - 1) % NSP;
                else if (key == K_EN) begin
                    seen = 0;
                    foreach (picks[i]) if (picks[i] == m_cursor) seen = 1;
                    if (!seen) begin
                        picks.push_back(m_cursor);
                        if (picks.size() == 3) m_mode = 2;
                    end
                end else if (key == K_S) begin
                    if (picks.size() > 0) void'(picks.pop_back());
                end
            end
            2: m_mode = 3;
            3: if (eb) begin
                m_last = res;
                if (res) m_wins = (m_wins < 255) ? m_wins + 1 : 255;
                else     m_losses = (m_losses < 255) ? m_losses + 1 : 255;
                m_hold = HOLD;
                m_mode = 4;
            end
            default: begin
                if ((evt && key == K_EN) || m_hold == 0) m_mode = 0;
                else m_hold = m_hold - 1;
            end
        endcase
    endfunction

    function automatic logic [8:0] model_team();
        logic [8:0] t = '0;
        foreach (picks[i]) t[i*3 +: 3] = 3'(picks[i]);
        return t;
    endfunction

    function automatic int model_screen();
        case (m_mode)
            0: return 0;
            1: return 1;
            2, 3: return 2;
            default: return 3;
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endfunction

    task automatic check_model();
        chk("m.screen", 32'(screen), 32'(model_screen()));
        chk("m.is_battle", 32'(bif.is_battle), 32'(m_mode == 3));
        chk("m.team", 32'(bif.team), 32'(model_team()));
        chk("m.cursor", 32'(cursor), 32'(m_cursor));
        chk("m.picked", 32'(picked_count), 32'(picks.size()));
        chk("m.last", 32'(last_result), 32'(m_last));
        chk("m.wins", 32'(wins), 32'(m_wins));
        chk("m.losses", 32'(losses), 32'(m_losses));
    endtask

    // One clock: advance the model with the inputs the DUT is about to sample, then compare.
    task automatic tick();
        model_step(Reset, int'(keycode), bif.end_battle, bif.result);
        @(posedge Clk);
        #1;
        check_model();
    endtask

    task automatic press(input logic [7:0] k);
        keycode = k; tick();
        keycode = 8'h00; tick();
    endtask

    task automatic enter_battle();
        press(K_EN);            // title -> select
        press(K_EN);            // pick 0
        press(K_D); press(K_EN); // pick 1
        press(K_D); press(K_EN); // pick 2 -> arm, release cycle -> battle
    endtask

    task automatic play_battle(input bit res);
        enter_battle();
        bif.end_battle = 1'b1; bif.result = res; tick();
        bif.end_battle = 1'b0;
        press(K_EN);            // leave result early
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst;
        logic [7:0] key;
        logic [1:0] scr;
        logic [2:0] cur;
        logic [1:0] pk;
        logic       ib;
        logic [8:0] tm;
    } vec_t;
    vec_t vq[$];

    function automatic void add(input logic rst, input logic [7:0] key, input logic [1:0] scr,
                                input logic [2:0] cur, input logic [1:0] pk, input logic ib,
                                input logic [8:0] tm);
        vec_t v;
        v.rst = rst; v.key = key; v.scr = scr; v.cur = cur; v.pk = pk; v.ib = ib; v.tm = tm;
        vq.push_back(v);
    endfunction

    initial begin
        int n;
        int hold_len;
        logic [7:0] rk;

        Reset = 1'b1; keycode = 8'h00; bif.end_battle = 1'b0; bif.result = 1'b0;

        //   rst key    scr cur pk ib team{s2,s1,s0}
        add(1, 8'h00, 0, 0, 0, 0, {3'd0, 3'd0, 3'd0});
        add(0, K_EN,  1, 0, 0, 0, {3'd0, 3'd0, 3'd0});
        add(0, 8'h00, 1, 0, 0, 0, {3'd0, 3'd0, 3'd0});
        add(0, K_A,   1, 5, 0, 0, {3'd0, 3'd0, 3'd0});  // wrap 0 -> 5
        add(0, 8'h00, 1, 5, 0, 0, {3'd0, 3'd0, 3'd0});
        add(0, K_D,   1, 0, 0, 0, {3'd0, 3'd0, 3'd0});  // wrap 5 -> 0
        add(0, K_D,   1, 0, 0, 0, {3'd0, 3'd0, 3'd0});  // held: no event
        add(0, 8'h00, 1, 0, 0, 0, {3'd0, 3'd0, 3'd0});
        add(0, K_D,   1, 1, 0, 0, {3'd0, 3'd0, 3'd0});
        add(0, K_EN,  1, 1, 1, 0, {3'd0, 3'd0, 3'd1});  // D -> ENTER directly: event
        add(0, 8'h00, 1, 1, 1, 0, {3'd0, 3'd0, 3'd1});
        add(0, K_EN,  1, 1, 1, 0, {3'd0, 3'd0, 3'd1});  // duplicate ignored
        add(0, 8'h00, 1, 1, 1, 0, {3'd0, 3'd0, 3'd1});
        add(0, K_W,   1, 1, 1, 0, {3'd0, 3'd0, 3'd1});  // W ignored
        add(0, 8'h00, 1, 1, 1, 0, {3'd0, 3'd0, 3'd1});
        add(0, K_D,   1, 2, 1, 0, {3'd0, 3'd0, 3'd1});
        add(0, 8'h00, 1, 2, 1, 0, {3'd0, 3'd0, 3'd1});
        add(0, K_D,   1, 3, 1, 0, {3'd0, 3'd0, 3'd1});
        add(0, K_EN,  1, 3, 2, 0, {3'd0, 3'd3, 3'd1});
        add(0, K_S,   1, 3, 1, 0, {3'd0, 3'd0, 3'd1});  // vacated slot cleared
        add(0, 8'h00, 1, 3, 1, 0, {3'd0, 3'd0, 3'd1});
        add(0, K_D,   1, 4, 1, 0, {3'd0, 3'd0, 3'd1});
        add(0, K_EN,  1, 4, 2, 0, {3'd0, 3'd4, 3'd1});
        add(0, K_A,   1, 3, 2, 0, {3'd0, 3'd4, 3'd1});
        add(0, 8'h00, 1, 3, 2, 0, {3'd0, 3'd4, 3'd1});
        add(0, K_A,   1, 2, 2, 0, {3'd0, 3'd4, 3'd1});
        add(0, K_EN,  2, 2, 3, 0, {3'd2, 3'd4, 3'd1});  // Arm: is_battle still 0
        add(0, 8'h00, 2, 2, 3, 1, {3'd2, 3'd4, 3'd1});  // InBattle
        add(0, K_S,   2, 2, 3, 1, {3'd2, 3'd4, 3'd1});  // keys ignored in battle
        add(0, 8'h00, 2, 2, 3, 1, {3'd2, 3'd4, 3'd1});

        foreach (vq[i]) begin
            Reset = vq[i].rst; keycode = vq[i].key;
            tick();
            chk($sformatf("vec%0d.screen", i), 32'(screen), 32'(vq[i].scr));
            chk($sformatf("vec%0d.cursor", i), 32'(cursor), 32'(vq[i].cur));
            chk($sformatf("vec%0d.picked", i), 32'(picked_count), 32'(vq[i].pk));
            chk($sformatf("vec%0d.is_battle", i), 32'(bif.is_battle), 32'(vq[i].ib));
            chk($sformatf("vec%0d.team", i), 32'(bif.team), 32'(vq[i].tm));
        end

        // Win pulse: is_battle drops next cycle, result screen, score updated.
        bif.end_battle = 1'b1; bif.result = 1'b1; tick();
        bif.end_battle = 1'b0; bif.result = 1'b0;
        chk("win.is_battle", 32'(bif.is_battle), 32'd0);
        chk("win.screen", 32'(screen), 32'd3);
        chk("win.wins", 32'(wins), 32'd1);
        chk("win.last", 32'(last_result), 32'd1);

        // Timed return: HOLD+1 cycles in Result with no keys, bounded wait.
        n = 0;
        while (screen == 2'd3 && n < 20) begin tick(); n++; end
        chk("hold.cycles", 32'(n), 32'(HOLD + 1));
        chk("hold.screen", 32'(screen), 32'd0);

        // end_battle outside InBattle is ignored.
        bif.end_battle = 1'b1; bif.result = 1'b0; tick();
        bif.end_battle = 1'b0;
        chk("title_eb.losses", 32'(losses), 32'd0);
        chk("title_eb.wins", 32'(wins), 32'd1);
        chk("title_eb.screen", 32'(screen), 32'd0);

        // Hold ENTER for 50 cycles from Title: exactly one transition, no picks.
        keycode = K_EN;
        for (int i = 0; i < 50; i++) tick();
        keycode = 8'h00; tick();
        chk("hold_enter.screen", 32'(screen), 32'd1);
        chk("hold_enter.picked", 32'(picked_count), 32'd0);
        // back to Title via a full battle lost: first drop into the normal flow
        press(K_EN); press(K_D); press(K_EN); press(K_D); press(K_EN);
        bif.end_battle = 1'b1; bif.result = 1'b0; tick();
        bif.end_battle = 1'b0;
        chk("loss.losses", 32'(losses), 32'd1);
        chk("loss.last", 32'(last_result), 32'd0);
        press(K_EN);

        // Drive wins to saturation.
        for (int i = 0; i < 254; i++) play_battle(1'b1);
        chk("sat.wins255", 32'(wins), 32'd255);
        play_battle(1'b1);
        chk("sat.wins_hold", 32'(wins), 32'd255);
        play_battle(1'b0);
        chk("sat.loss_only_w", 32'(wins), 32'd255);
        chk("sat.loss_only_l", 32'(losses), 32'd2);

        // Reset mid-battle.
        enter_battle();
        chk("rst.pre_ib", 32'(bif.is_battle), 32'd1);
        Reset = 1'b1; tick(); Reset = 1'b0;
        chk("rst.screen", 32'(screen), 32'd0);
        chk("rst.is_battle", 32'(bif.is_battle), 32'd0);
        chk("rst.team", 32'(bif.team), 32'd0);
        chk("rst.wins", 32'(wins), 32'd0);
        chk("rst.losses", 32'(losses), 32'd0);

        // Random phase: held keys, stray codes, random engine pulses, rare resets.
        for (int c = 0; c < 3000; ) begin
            case ($urandom_range(0, 7))
                0:       rk = 8'h00;
                1:       rk = K_A;
                2:       rk = K_D;
                3:       rk = K_S;
                4, 5:    rk = K_EN;
                6:       rk = K_W;
                default: rk = 8'($urandom);
            endcase
            hold_len = $urandom_range(1, 4);
            for (int h = 0; h < hold_len; h++) begin
                keycode        = rk;
                Reset          = ($urandom_range(0, 299) == 0);
                bif.end_battle = ($urandom_range(0, 5) == 0);
                bif.result     = 1'($urandom);
                tick();
                c++;
            end
        end
        Reset = 1'b0; bif.end_battle = 1'b0; keycode = 8'h00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
